// File: rtl/io_ctrl.sv
// io_ctrl: CPU-bus register file driving board LEDs and 7-segment hex digits,
// with a shared blink prescaler and fully registered pad outputs.

// Per-digit decoder: hex nibble to active-low gfedcba pattern, or blank.
module io_ctrl_seg_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  // Glyph lookup; blanking overrides the glyph.
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end
endmodule

module io_ctrl #(
  parameter int LED_W      = 10,
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [2:0]              addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    rvalid,
  output logic [LED_W-1:0]        led_out,
  output logic [7*NUM_DIGITS-1:0] seg_out
);
  localparam int       CNT_W     = $clog2(BLINK_DIV);
  localparam int       RD_STAGES = 1;
  localparam logic [2:0] A_LED   = 3'd0;
  localparam logic [2:0] A_DIGIT = 3'd1;
  localparam logic [2:0] A_EN    = 3'd2;
  localparam logic [2:0] A_DBLNK = 3'd3;
  localparam logic [2:0] A_LBLNK = 3'd4;
  localparam logic [2:0] A_SYNC  = 3'd5;
  localparam logic [6:0] GLYPH0  = 7'b1000000;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

  bus_req_t                      req;
  logic [LED_W-1:0]              led_r, lblnk_r;
  logic [4*NUM_DIGITS-1:0]       dig_r;
  logic [NUM_DIGITS-1:0]         en_r, dblnk_r, blank_vec;
  logic [CNT_W-1:0]              cnt;
  logic                          phase;
  logic                          sync_wr;
  logic [31:0]                   rd_mux;
  logic [RD_STAGES-1:0]          vld_pipe;
  logic [NUM_DIGITS-1:0][6:0]    seg_nxt;

  assign req     = '{we: we, re: re, addr: addr, wdata: wdata};
  assign sync_wr = req.we && (req.addr == A_SYNC);

  // Register file writes; unlisted addresses fall through untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r   <= '0;
      dig_r   <= '0;
      en_r    <= '1;
      dblnk_r <= '0;
      lblnk_r <= '0;
    end else if (req.we) begin
      case (req.addr)
        A_LED:   led_r   <= req.wdata[LED_W-1:0];
        A_DIGIT: dig_r   <= req.wdata[4*NUM_DIGITS-1:0];
        A_EN:    en_r    <= req.wdata[NUM_DIGITS-1:0];
        A_DBLNK: dblnk_r <= req.wdata[NUM_DIGITS-1:0];
        A_LBLNK: lblnk_r <= req.wdata[LED_W-1:0];
        default: ;
      endcase
    end
  end

  // Blink prescaler; a SYNC write takes priority over the wrap.
  always_ff @(posedge clk) begin
    if (rst || sync_wr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Read mux sees pre-edge register values, so same-edge writes read old data.
  always_comb begin
    rd_mux = '0;
    case (req.addr)
      A_LED:   rd_mux[LED_W-1:0]        = led_r;
      A_DIGIT: rd_mux[4*NUM_DIGITS-1:0] = dig_r;
      A_EN:    rd_mux[NUM_DIGITS-1:0]   = en_r;
      A_DBLNK: rd_mux[NUM_DIGITS-1:0]   = dblnk_r;
      A_LBLNK: rd_mux[LED_W-1:0]        = lblnk_r;
      default: rd_mux = '0;
    endcase
  end

  // Read data capture and valid pipeline; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      vld_pipe <= '0;
    end else begin
      if (req.re) rdata <= rd_mux;
      vld_pipe[0] <= req.re;
      for (int s = 1; s < RD_STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign rvalid = vld_pipe[RD_STAGES-1];

  assign blank_vec = ~en_r | (dblnk_r & {NUM_DIGITS{phase}});

  io_ctrl_seg_lane u_lane [NUM_DIGITS-1:0] (
    .nib   (dig_r),
    .blank (blank_vec),
    .seg   (seg_nxt)
  );

  // Pad registers; reset shows glyph 0 on every digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out <= '0;
      seg_out <= {NUM_DIGITS{GLYPH0}};
    end else begin
      led_out <= led_r & ~(lblnk_r & {LED_W{phase}});
      seg_out <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_io_ctrl.sv
// Scoreboard bench for io_ctrl: driver runs a behavioural model and queues
// expected pad/read results; a monitor pops and compares after each edge.
module tb_io_ctrl;
  localparam int LW = 10;
  localparam int ND = 6;
  localparam int BD = 4;

  logic              clk = 1'b1;
  logic              rst, we, re;
  logic [2:0]        addr;
  logic [31:0]       wdata, rdata;
  logic              rvalid;
  logic [LW-1:0]     led_out;
  logic [7*ND-1:0]   seg_out;

  io_ctrl #(.LED_W(LW), .NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .led_out(led_out), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0]   led;
    logic [7*ND-1:0] seg;
    logic            rv;
    logic [31:0]     rdata;
  } exp_t;

  exp_t        out_q[$];
  logic [31:0] rd_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state, kept as plain values and a counter.
  int          m_led, m_dig, m_en, m_dblnk, m_lblnk;
  int          m_cnt;
  bit          m_phase;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_led = 0; m_dig = 0; m_en = (1 << ND) - 1; m_dblnk = 0; m_lblnk = 0;
    m_cnt = 0; m_phase = 0; m_rdata = 0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0: return 32'(m_led);
      1: return 32'(m_dig);
      2: return 32'(m_en);
      3: return 32'(m_dblnk);
      4: return 32'(m_lblnk);
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the reference: queue what the pads/read show after it.
  task automatic model_step(input bit r, input bit w, input bit rd, input int a, input logic [31:0] d);
    exp_t e;
    if (r) begin
      model_reset();
      e.led = '0; e.rv = 1'b0; e.rdata = '0;
      for (int i = 0; i < ND; i++) e.seg[7*i +: 7] = glyph[0];
      out_q.push_back(e);
      return;
    end
    e.led = LW'(m_led & ~(m_phase ? m_lblnk : 0));
    for (int i = 0; i < ND; i++) begin
      int nib;
      bit lit;
      nib = (m_dig >> (4*i)) & 15;
      lit = ((m_en >> i) & 1) && !(((m_dblnk >> i) & 1) && m_phase);
      e.seg[7*i +: 7] = lit ? glyph[nib] : 7'h7F;
    end
    if (rd) begin
      m_rdata = model_read(a);
      rd_q.push_back(m_rdata);
    end
    e.rv = rd; e.rdata = m_rdata;
    out_q.push_back(e);
    if (w) begin
      case (a)
        0: m_led   = int'(d) & ((1 << LW) - 1);
        1: m_dig   = int'(d) & ((1 << (4*ND)) - 1);
        2: m_en    = int'(d) & ((1 << ND) - 1);
        3: m_dblnk = int'(d) & ((1 << ND) - 1);
        4: m_lblnk = int'(d) & ((1 << LW) - 1);
        default: ;
      endcase
    end
    if (w && a == 5) begin
      m_cnt = 0; m_phase = 0;
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == BD) begin m_cnt = 0; m_phase = !m_phase; end
    end
  endtask

  task automatic apply(input bit r, input bit w, input bit rd, input int a, input logic [31:0] d);
    @(negedge clk);
    rst = r; we = w; re = rd; addr = 3'(a); wdata = d;
    model_step(r, w, rd, a, d);
  endtask

  // Monitor: pads are presented every cycle, read data whenever rvalid pulses.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_q.size() > 0) begin
      e = out_q.pop_front();
      n_vec++;
      if (led_out !== e.led) begin
        n_err++; $display("FAIL led_out got %h want %h @%0t", led_out, e.led, $time);
      end
      n_vec++;
      if (seg_out !== e.seg) begin
        n_err++; $display("FAIL seg_out got %h want %h @%0t", seg_out, e.seg, $time);
      end
      n_vec++;
      if (rvalid !== e.rv) begin
        n_err++; $display("FAIL rvalid got %b want %b @%0t", rvalid, e.rv, $time);
      end
      n_vec++;
      if (rdata !== e.rdata) begin
        n_err++; $display("FAIL rdata_hold got %h want %h @%0t", rdata, e.rdata, $time);
      end
      if (rvalid === 1'b1) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++; $display("FAIL read_extra got %h want none @%0t", rdata, $time);
        end else begin
          logic [31:0] x;
          x = rd_q.pop_front();
          if (rdata !== x) begin
            n_err++; $display("FAIL read_data got %h want %h @%0t", rdata, x, $time);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    model_reset();
    // reset and power-up read of EN
    apply(1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 1, 2, 0);
    // LED write and read-back
    apply(0, 1, 0, 0, 32'h2A5);
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0);
    // digits
    apply(0, 1, 0, 1, 32'hC0FFEE);
    apply(0, 0, 1, 1, 0);
    // blink masks, then watch several half-periods
    apply(0, 1, 0, 3, 32'h01);
    apply(0, 1, 0, 4, 32'h001);
    for (int i = 0; i < 14; i++) apply(0, 0, 0, 0, 0);
    // SYNC when phase is 1, then watch the next wrap
    while (!m_phase) apply(0, 0, 0, 0, 0);
    apply(0, 1, 0, 5, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) apply(0, 0, (i == 2), 5, 0);
    // same-edge write+read, then re-read
    apply(0, 1, 1, 0, 32'h155);
    apply(0, 0, 1, 0, 0);
    // reset mid-blink
    while (!m_phase) apply(0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 1, 2, 0);
    apply(0, 0, 1, 4, 0);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit r, w, rd;
      int a;
      r  = ($urandom_range(0, 79) == 0);
      w  = ($urandom_range(0, 2) == 0);
      rd = $urandom_range(0, 1) == 1;
      a  = $urandom_range(0, 7);
      apply(r, w, rd, a, $urandom);
    end
    apply(0, 0, 0, 0, 0);
    @(posedge clk); #2;
    if (rd_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL read_missing got %0d pending want 0", rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
